wei_stream_loader: RTL
======================

# wei_stream_loader

Upstream fill stage for the weight buffer. It parses a compressed kernel stream arriving from the memory-controller DMA and generates the write strobes and data for the weight-flag RAM and the weight column buffer. Each kernel is one flag beat (one bit per kernel tap, 1 = non-zero) followed by one weight beat per set flag bit. Dense mode forces all flags to 1 and expects `KERNEL_SIZE` weight beats per kernel.

## Interface
- `DATA_WIDTH`, 8: width of one weight.
- `KERNEL_SIZE`, 9: taps per kernel, which is also the flag width.
- `IN_WIDTH`, 16: stream beat width. Must be ≥ max(`DATA_WIDTH`, `KERNEL_SIZE`).
- `KCNT_WIDTH`, 8: width of the kernel-count field.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: one-cycle pulse that begins a load. Ignored while `busy`.
- `mode` in 1: 1 = sparse, 0 = dense. Sampled on an accepted `start`.
- `num_kernels` in `KCNT_WIDTH`: number of kernels to load. Sampled on an accepted `start`.
- `buf_full` in 1: weight buffer back-pressure. While high, `in_ready` is low.
- `in_valid` in 1: stream beat valid.
- `in_data` in `IN_WIDTH`: stream beat.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `wr_req_wei_flag` out 1: flag RAM write strobe.
- `wr_data_wei_flag` out `KERNEL_SIZE`: flag word.
- `wr_req_wei` out 1: weight write strobe.
- `wr_data_wei` out `DATA_WIDTH`: weight value.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the last kernel is complete.

## Operation
- States: `IDLE`, `FLAG`, `DATA`, `DONE`.
- `IDLE`:
  - `start` → latch `mode`, latch `num_kernels` into `kcnt`.
  - If `num_kernels` = 0, go to `DONE`; otherwise go to `FLAG`.
- `FLAG`, on an accepted beat:
  - Flag f = `in_data[KERNEL_SIZE-1:0]` in sparse mode, all-ones in dense mode. In dense mode the flag beat is still consumed.
  - Issue a flag write of f.
  - Load `wcnt` = popcount(f), width clog2(`KERNEL_SIZE`+1).
  - If `wcnt` = 0, the kernel is complete immediately: do not enter `DATA`, apply the kernel-complete rule.
  - Otherwise go to `DATA`.
- `DATA`, on an accepted beat:
  - Issue a weight write of `in_data[DATA_WIDTH-1:0]` and decrement `wcnt`.
  - When `wcnt` reaches 0, apply the kernel-complete rule.
- Kernel-complete rule: decrement `kcnt`. If it reaches 0 go to `DONE`, else go to `FLAG`.
- `DONE`: assert `done` for one cycle, then return to `IDLE`.
- `in_ready` = (state ∈ {`FLAG`, `DATA`}) && !`buf_full`.
- Unused upper `in_data` bits are ignored.
- `start` while `busy` has no effect. `start` in the same cycle as `done` is ignored.

## Timing
- Reset values: `in_ready` 0, `wr_req_wei_flag` 0, `wr_data_wei_flag` 0, `wr_req_wei` 0, `wr_data_wei` 0, `busy` 0, `done` 0. State `IDLE`, counters 0.
- Write outputs are registered: a beat accepted in cycle n gives the strobe plus data in cycle n+1, high for exactly one cycle.
- `wr_req_wei_flag` and `wr_req_wei` are never high in the same cycle.
- Throughput: one beat per cycle while `in_valid` is high and `buf_full` is low.
- `start`→`busy` latency: 1 cycle.
- `done` coincides with the write strobe of the final beat; both are in cycle n+1 after the final beat is accepted.
- When `num_kernels` = 0, `done` rises 2 cycles after `start`.
- `buf_full` rising in cycle n blocks acceptance in cycle n; a beat accepted before that still writes.
- Reset mid-load aborts immediately. No partial strobe is emitted after reset deasserts.

## Structure
- Shared package holds:
  - the state enum (`LD_IDLE`, `LD_FLAG`, `LD_DATA`, `LD_DONE`);
  - popcount width derived from `KERNEL_SIZE`;
  - reuse of `DATA_WIDTH` / `KERNEL_SIZE` from `def_params.vh`.
- One sub-module: `popcount_kernel` (combinational, `KERNEL_SIZE` → count), reused for row valid counts elsewhere.

## Test plan
- Sparse, 2 kernels: flags 0x1A5 and 0x003, weights 1..7.
  - Expect: flag write 0x1A5, 5 weight writes 1..5; flag write 0x003, 2 weight writes 6,7.
  - `done` high with the strobe of weight 7; 9 accepted beats total.
- Dense, 1 kernel: flag beat 0x000, then 9 weights.
  - Expect: flag write 0x1FF and 9 weight writes; `in_ready` low after the 10th beat.
- Sparse, 3 kernels: middle flag 0x000.
  - Expect: that kernel produces a flag write only, with no weight beat consumed; the third flag is accepted on the next beat.
- Back-pressure: `buf_full` high for 3 cycles in the middle of `DATA`.
  - Expect: `in_ready` 0 for those cycles, no strobes, no data lost; the order of written weights is unchanged.
- Edge cases:
  - `num_kernels` = 0 → `done` 2 cycles after `start`, no writes.
  - `start` while busy → ignored.
- Reset pulse in the middle of `DATA`, followed by a fresh `start`.
  - Expect: all outputs 0 during reset.
  - The new load runs exactly as from power-up.

Source files
------------

// File: rtl/wei_stream_loader_pkg.sv
// Shared definitions for the weight-stream loader: default geometry, counter
// widths and the load sequencer state encoding.
package wei_stream_loader_pkg;

   // Default geometry, kept in step with the project-wide definitions
   localparam int unsigned LD_DATA_WIDTH  = 8;
   localparam int unsigned LD_KERNEL_SIZE = 9;
   localparam int unsigned LD_IN_WIDTH    = 16;
   localparam int unsigned LD_KCNT_WIDTH  = 8;

   // Bits needed to hold a population count of a word of the given width
   function automatic int unsigned popcnt_width(input int unsigned bits);
      return int'($clog2(bits + 1));
   endfunction

   localparam int unsigned LD_WCNT_WIDTH = popcnt_width(LD_KERNEL_SIZE);

   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_FLAG = 2'd1,
      LD_DATA = 2'd2,
      LD_DONE = 2'd3
   } ld_state_e;

endpackage

// File: rtl/wei_stream_loader_popcount_kernel.sv
// Combinational population count of a kernel-wide flag word.
module popcount_kernel #(
   parameter int unsigned WIDTH     = 9,
   parameter int unsigned CNT_WIDTH = 4
) (
   input  logic [WIDTH-1:0]     bits_i,
   output logic [CNT_WIDTH-1:0] count_o
);

   // Sum of set bits
   always_comb begin
      count_o = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         count_o = count_o + CNT_WIDTH'(bits_i[i]);
      end
   end

endmodule

// File: rtl/wei_stream_loader.sv
// Weight-buffer fill stage: parses the compressed kernel stream (flag beat
// followed by one weight beat per set flag bit) into flag-RAM and weight
// write strobes.
module wei_stream_loader
   import wei_stream_loader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = LD_DATA_WIDTH,
   parameter int unsigned KERNEL_SIZE = LD_KERNEL_SIZE,
   parameter int unsigned IN_WIDTH    = LD_IN_WIDTH,
   parameter int unsigned KCNT_WIDTH  = LD_KCNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   mode,
   input  logic [KCNT_WIDTH-1:0]  num_kernels,
   input  logic                   buf_full,
   input  logic                   in_valid,
   input  logic [IN_WIDTH-1:0]    in_data,
   output logic                   in_ready,
   output logic                   wr_req_wei_flag,
   output logic [KERNEL_SIZE-1:0] wr_data_wei_flag,
   output logic                   wr_req_wei,
   output logic [DATA_WIDTH-1:0]  wr_data_wei,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned WCNT_WIDTH = popcnt_width(KERNEL_SIZE);

   ld_state_e              state_q, state_d;
   logic                   mode_q, mode_d;
   logic [KCNT_WIDTH-1:0]  kcnt_q, kcnt_d;
   logic [WCNT_WIDTH-1:0]  wcnt_q, wcnt_d;
   logic                   flag_wr_q, flag_wr_d;
   logic [KERNEL_SIZE-1:0] flag_data_q, flag_data_d;
   logic                   wei_wr_q, wei_wr_d;
   logic [DATA_WIDTH-1:0]  wei_data_q, wei_data_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic                   accept_c;
   logic                   kernel_done_c;
   logic [KERNEL_SIZE-1:0] flag_c;
   logic [WCNT_WIDTH-1:0]  flag_cnt_c;
   logic                   unused_in_bits_c;

   // Upper stream bits carry no information for this stage
   assign unused_in_bits_c = ^in_data;

   // Ready must drop in the same cycle buf_full rises, so it is not registered
   assign in_ready = ((state_q == LD_FLAG) || (state_q == LD_DATA)) && !buf_full;
   assign accept_c = in_valid && in_ready;

   // Dense kernels carry every tap regardless of the flag beat contents
   assign flag_c = mode_q ? in_data[KERNEL_SIZE-1:0] : '1;

   popcount_kernel #(
      .WIDTH     (KERNEL_SIZE),
      .CNT_WIDTH (WCNT_WIDTH)
   ) u_popcount (
      .bits_i  (flag_c),
      .count_o (flag_cnt_c)
   );

   // Next-state, counters and write payloads for the load sequencer
   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      kcnt_d        = kcnt_q;
      wcnt_d        = wcnt_q;
      flag_wr_d     = 1'b0;
      flag_data_d   = flag_data_q;
      wei_wr_d      = 1'b0;
      wei_data_d    = wei_data_q;
      done_d        = 1'b0;
      kernel_done_c = 1'b0;

      case (state_q)
         LD_IDLE: begin
            if (start) begin
               mode_d  = mode;
               kcnt_d  = num_kernels;
               state_d = (num_kernels == '0) ? LD_DONE : LD_FLAG;
            end
         end
         LD_FLAG: begin
            if (accept_c) begin
               flag_wr_d   = 1'b1;
               flag_data_d = flag_c;
               wcnt_d      = flag_cnt_c;
               if (flag_cnt_c == '0) begin
                  kernel_done_c = 1'b1;
               end else begin
                  state_d = LD_DATA;
               end
            end
         end
         LD_DATA: begin
            if (accept_c) begin
               wei_wr_d   = 1'b1;
               wei_data_d = in_data[DATA_WIDTH-1:0];
               wcnt_d     = wcnt_q - WCNT_WIDTH'(1);
               if (wcnt_q == WCNT_WIDTH'(1)) begin
                  kernel_done_c = 1'b1;
               end
            end
         end
         LD_DONE: begin
            // A load that ended on a beat has already pulsed done; an empty
            // load pulses it here before returning to idle
            done_d = !done_q;
            if (done_q) begin
               state_d = LD_IDLE;
            end
         end
         default: begin
            state_d = LD_IDLE;
         end
      endcase

      // Kernel complete: retire it and either finish or fetch the next flag
      if (kernel_done_c) begin
         kcnt_d = kcnt_q - KCNT_WIDTH'(1);
         if (kcnt_q == KCNT_WIDTH'(1)) begin
            state_d = LD_DONE;
            done_d  = 1'b1;
         end else begin
            state_d = LD_FLAG;
         end
      end

      busy_d = (state_d != LD_IDLE);
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= LD_IDLE;
         mode_q      <= 1'b0;
         kcnt_q      <= '0;
         wcnt_q      <= '0;
         flag_wr_q   <= 1'b0;
         flag_data_q <= '0;
         wei_wr_q    <= 1'b0;
         wei_data_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         kcnt_q      <= kcnt_d;
         wcnt_q      <= wcnt_d;
         flag_wr_q   <= flag_wr_d;
         flag_data_q <= flag_data_d;
         wei_wr_q    <= wei_wr_d;
         wei_data_q  <= wei_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign wr_req_wei_flag  = flag_wr_q;
   assign wr_data_wei_flag = flag_data_q;
   assign wr_req_wei       = wei_wr_q;
   assign wr_data_wei      = wei_data_q;
   assign busy             = busy_q;
   assign done             = done_q;

endmodule
